// File: rtl/nios_ram_bist_master.sv
// Avalon-MM RAM self-test master: writes a pattern over a word range, reads it back and compares.
// Optional macro NIOS_RAM_BIST_LFSR_EN selects a 32-bit Galois LFSR pattern instead of seed+i.
module nios_ram_bist_master #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } pipe_t;

`ifdef NIOS_RAM_BIST_LFSR_EN
    localparam logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003);

    function automatic logic [DATA_W-1:0] pat_load(input logic [DATA_W-1:0] s);
        return (s == '0) ? DATA_W'(1) : s;
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
    endfunction
`else
    function automatic logic [DATA_W-1:0] pat_load(input logic [DATA_W-1:0] s);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] v);
        return v + 1'b1;
    endfunction
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [2:0]          drain_q, drain_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   writedata_q, writedata_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    pipe_t               pipe_q [READ_LATENCY];
    pipe_t               pipe_d [READ_LATENCY];
    pipe_t               tail;
    logic                last_idx;

    assign tail     = pipe_q[READ_LATENCY-1];
    assign last_idx = (idx_q == count_q - 1'b1);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        seed_d      = seed_q;
        drain_d     = drain_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_d       = err_q;
        first_d     = first_q;

        // Each read accepted by the RAM carries its expected word to the cycle its data returns.
        pipe_d[0] = '{vld: cs_q & ~wr_q, addr: address_q, exp: writedata_q};
        for (int j = 1; j < READ_LATENCY; j++) pipe_d[j] = pipe_q[j-1];

        if (tail.vld && (readdata != tail.exp)) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (err_q == '0) first_d = tail.addr;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    count_d     = word_count;
                    seed_d      = seed;
                    err_d       = '0;
                    first_d     = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    idx_d       = '0;
                    address_d   = base_addr;
                    writedata_d = pat_load(seed);
                    if (word_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRITE;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (last_idx) begin
                    state_d     = S_READ;
                    idx_d       = '0;
                    address_d   = base_q;
                    writedata_d = pat_load(seed_q);
                    wr_d        = 1'b0;
                end else begin
                    idx_d       = idx_q + 1'b1;
                    address_d   = address_q + 1'b1;
                    writedata_d = pat_next(writedata_q);
                end
            end
            S_READ: begin
                if (last_idx) begin
                    state_d = S_DRAIN;
                    cs_d    = 1'b0;
                    drain_d = 3'(READ_LATENCY - 1);
                end else begin
                    idx_d       = idx_q + 1'b1;
                    address_d   = address_q + 1'b1;
                    writedata_d = pat_next(writedata_q);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else               drain_d = drain_q - 1'b1;
            end
            S_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            seed_q      <= '0;
            drain_q     <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
            for (int j = 0; j < READ_LATENCY; j++) pipe_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            seed_q      <= seed_d;
            drain_q     <= drain_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_q     <= first_d;
            for (int j = 0; j < READ_LATENCY; j++) pipe_q[j] <= pipe_d[j];
        end
    end

    assign busy           = busy_q;
    assign clken          = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign address        = address_q;
    assign byteenable     = '1;
    assign chipselect     = cs_q;
    assign write          = wr_q;
    assign writedata      = writedata_q;

endmodule

// File: tb/tb_nios_ram_bist_master.sv
// Randomised bench for nios_ram_bist_master: behavioural RAM with fault injection plus a
// list-based reference model of the expected bus traffic, error count and completion time.
module tb_nios_ram_bist_master;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int ERR_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [ADDR_W:0]     word_count = '0;
    logic [DATA_W-1:0]   seed = '0;
    logic                busy, done, pass, chipselect, write, clken;
    logic [ERR_W-1:0]    err_count;
    logic [ADDR_W-1:0]   first_err_addr, address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata, readdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nios_ram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .seed(seed), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .write(write), .writedata(writedata), .clken(clken),
        .readdata(readdata)
    );

    // RAM model spans the whole address space so the wrap test lands on real storage.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q = '0;
    logic              force_en = 1'b0;
    logic [ADDR_W-1:0] force_addr = '0;
    logic [DATA_W-1:0] stuck_mask = '0;

    always @(posedge clk) begin
        if (chipselect && clken) begin
            if (write) begin
                for (int b = 0; b < DATA_W/8; b++)
                    if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
            end else if (force_en && address == force_addr) begin
                rd_q <= 32'hDEAD_BEEF;
            end else begin
                rd_q <= mem[address] | stuck_mask;
            end
        end
    end
    assign readdata = rd_q;

    logic [ADDR_W-1:0] wr_addr_log [$];
    logic [DATA_W-1:0] wr_data_log [$];
    logic [ADDR_W-1:0] rd_addr_log [$];

    always @(negedge clk) begin
        if (chipselect) begin
            if (write) begin
                wr_addr_log.push_back(address);
                wr_data_log.push_back(writedata);
            end else begin
                rd_addr_log.push_back(address);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_pat(input logic [DATA_W-1:0] s, input int i);
        logic [DATA_W-1:0] v;
`ifdef NIOS_RAM_BIST_LFSR_EN
        v = (s == 0) ? 32'h1 : s;
        for (int k = 0; k < i; k++) begin
            if (v[0]) v = {1'b0, v[31:1]} ^ 32'h8020_0003;
            else      v = {1'b0, v[31:1]};
        end
`else
        v = s + DATA_W'(i);
`endif
        return v;
    endfunction

    task automatic run_test(input string name, input logic [ADDR_W-1:0] b, input int n,
                            input logic [DATA_W-1:0] s, input bit pulse_busy);
        logic [ADDR_W-1:0] exp_addr [$];
        logic [DATA_W-1:0] exp_data [$];
        logic [DATA_W-1:0] rv;
        logic [ADDR_W-1:0] exp_first;
        int exp_err, cyc, bad_wr, bad_rd, exp_cyc;
        bit seen;

        exp_err = 0;
        exp_first = '0;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'((int'(b) + i) % DEPTH));
            exp_data.push_back(model_pat(s, i));
            if (force_en && exp_addr[i] == force_addr) rv = 32'hDEAD_BEEF;
            else                                       rv = exp_data[i] | stuck_mask;
            if (rv != exp_data[i]) begin
                if (exp_err == 0) exp_first = exp_addr[i];
                exp_err++;
            end
        end
        exp_cyc = (n == 0) ? 2 : 2 * n + 3;

        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();

        @(negedge clk);
        base_addr  = b;
        word_count = (ADDR_W+1)'(n);
        seed       = s;
        start      = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (cyc < 2 * n + 20) begin
            @(negedge clk);
            cyc++;
            start = pulse_busy && (cyc == 4);
            if (start) begin
                base_addr  = b + 13'd77;
                word_count = 14'd1;
                seed       = ~s;
            end
            if (cyc == 1) check({name, " busy_after_start"}, 64'(busy), 64'd1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({name, " done_seen"}, 64'(seen), 64'd1);
        check({name, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        check({name, " pass"}, 64'(pass), 64'(exp_err == 0));
        check({name, " err_count"}, 64'(err_count), 64'(exp_err));
        check({name, " first_err_addr"}, 64'(first_err_addr), 64'(exp_first));

        bad_wr = 0;
        bad_rd = 0;
        for (int i = 0; i < n && i < wr_addr_log.size(); i++)
            if (wr_addr_log[i] != exp_addr[i] || wr_data_log[i] != exp_data[i]) bad_wr++;
        for (int i = 0; i < n && i < rd_addr_log.size(); i++)
            if (rd_addr_log[i] != exp_addr[i]) bad_rd++;
        check({name, " write_count"}, 64'(wr_addr_log.size()), 64'(n));
        check({name, " read_count"}, 64'(rd_addr_log.size()), 64'(n));
        check({name, " write_seq_bad"}, 64'(bad_wr), 64'd0);
        check({name, " read_seq_bad"}, 64'(bad_rd), 64'd0);

        @(negedge clk);
        check({name, " done_one_cycle"}, 64'(done), 64'd0);
        check({name, " pass_held"}, 64'(pass), 64'(exp_err == 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        logic [ADDR_W-1:0] rb;
        int rn;

        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst pass", 64'(pass), 64'd0);
        check("rst cs_wr_clken", 64'({chipselect, write, clken}), 64'd0);
        check("rst err_count", 64'(err_count), 64'd0);
        check("rst first_err_addr", 64'(first_err_addr), 64'd0);
        check("rst address", 64'(address), 64'd0);
        check("rst writedata", 64'(writedata), 64'd0);
        check("byteenable", 64'(byteenable), 64'hF);
        reset = 1'b0;

        run_test("t1_basic", 13'h0000, 16, 32'hA000_0000, 1'b1);

        force_en   = 1'b1;
        force_addr = 13'h105;
        run_test("t2_fault", 13'h0100, 8, $urandom, 1'b0);
        force_en = 1'b0;

        run_test("t3_wrap", 13'h1FFE, 4, $urandom, 1'b0);
        run_test("t4_zero", 13'h0123, 0, $urandom, 1'b0);

        // Abort in the middle of the read pass.
        @(negedge clk);
        base_addr  = 13'h0040;
        word_count = 14'd16;
        seed       = 32'h1234_5678;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5 busy_after_reset", 64'(busy), 64'd0);
        check("t5 cs_after_reset", 64'(chipselect), 64'd0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t5 no_done_after_abort", 64'(dones), 64'd0);
        run_test("t5_restart", 13'h0040, 16, 32'h1234_5678, 1'b0);

        stuck_mask = 32'h0000_0080;
        run_test("t6_stuck", 13'h0200, 16, 32'h0, 1'b0);
        stuck_mask = '0;
        run_test("t6_clean", 13'h0200, 16, 32'h0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            rb = ADDR_W'($urandom_range(0, DEPTH - 1));
            rn = $urandom_range(1, 40);
            force_en   = $urandom_range(0, 1);
            force_addr = rb + ADDR_W'($urandom_range(0, rn - 1));
            run_test($sformatf("rnd%0d", r), rb, rn, $urandom, r[0]);
        end
        force_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
